// File: rtl/grom_pkg.sv
// Shared definitions for the GROM byte port: FSM state encoding, the
// port-select constants and a small helper used for address read-back.
package grom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_FETCH = 2'd2,
        ST_LOAD  = 2'd3
    } grom_state_t;

    localparam logic MODE_DATA = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    // Selects which half of the address register an address read returns:
    // the high byte first (lo_byte = 0), then the low byte.
    function automatic logic [7:0] addr_byte(input logic [15:0] addr, input logic lo_byte);
        return lo_byte ? addr[7:0] : addr[15:8];
    endfunction

endpackage

// File: rtl/grom_port_if.sv
// CPU-side request/response bundle of the GROM byte port.
interface grom_port_if;

    logic       req;
    logic       we;
    logic       mode;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ack;
    logic       busy;

    modport master (
        output req, we, mode, din,
        input  dout, ack, busy
    );

    modport slave (
        input  req, we, mode, din,
        output dout, ack, busy
    );

endinterface

// File: rtl/grom_port.sv
// GROM-style byte port: 16-bit auto-incrementing address register, one-byte
// prefetch buffer and address-byte phase flag, driving an external ROM with a
// one-cycle registered read.
module grom_port
    import grom_pkg::*;
#(
    parameter int ROM_AW = 13
) (
    input  logic              clk,
    input  logic              reset,
    grom_port_if.slave        bus,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data
);

    grom_state_t       state_q,    state_d;
    logic [15:0]       addr_q,     addr_d;
    logic [7:0]        pbuf_q,     pbuf_d;
    logic [7:0]        dout_q,     dout_d;
    logic              phase_q,    phase_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              ack_q,      ack_d;
    logic              busy_q,     busy_d;

    // Next-state logic: requests are only decoded in IDLE; FETCH/LOAD/ACK
    // run to completion and ignore any req seen meanwhile.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pbuf_d     = pbuf_q;
        dout_d     = dout_q;
        phase_d    = phase_q;
        rom_addr_d = rom_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (bus.mode == MODE_ADDR) begin
                        if (bus.we) begin
                            // Bytes shift in from the bottom; the second byte
                            // completes the address and triggers a prefetch.
                            addr_d  = {addr_q[7:0], bus.din};
                            phase_d = ~phase_q;
                            state_d = phase_q ? ST_FETCH : ST_ACK;
                        end else begin
                            dout_d  = addr_byte(addr_q, phase_q);
                            phase_d = ~phase_q;
                            state_d = ST_ACK;
                        end
                    end else begin
                        // Data read returns the byte prefetched earlier; a data
                        // write is accepted but the ROM is read-only, so it only
                        // advances the address like a read does.
                        if (!bus.we) begin
                            dout_d = pbuf_q;
                        end
                        phase_d = 1'b0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // Increment wraps inside the ROM window; upper address bits stay.
                pbuf_d                = rom_data;
                addr_d[ROM_AW-1:0]    = addr_q[ROM_AW-1:0] + ROM_AW'(1);
                state_d               = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The ROM address is captured only on entry to FETCH so it already
        // reflects a just-completed address write.
        if (state_q == ST_IDLE && state_d == ST_FETCH) begin
            rom_addr_d = addr_d[ROM_AW-1:0];
        end

        ack_d  = (state_d == ST_ACK) || (state_d == ST_LOAD);
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset may abort a prefetch at any point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            pbuf_q     <= '0;
            dout_q     <= '0;
            phase_q    <= 1'b0;
            rom_addr_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pbuf_q     <= pbuf_d;
            dout_q     <= dout_d;
            phase_q    <= phase_d;
            rom_addr_q <= rom_addr_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: doc/grom_port.md
# grom_port

GROM-style byte port between the CPU bus decoder and a `rom16` instance holding GROM contents. It holds a 16-bit auto-incrementing address register, a one-byte prefetch buffer and an address-byte phase flag. It drives the ROM's address and consumes its registered data output with the ROM's one-cycle read latency. One instance serves one GROM space; the parent instantiates the ROM.

## Interface
Parameters:
- `ROM_AW`, default 13: ROM address width. The increment wraps within the low `ROM_AW` bits.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: one-cycle request strobe; issue only while `busy`=0.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `mode` in 1: 1 = address port, 0 = data port; sampled with `req`.
- `din` in 8: write data; sampled with `req`.
- `dout` out 8: read data, registered; valid from the cycle after `req` and held until the next read.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high while state ≠ IDLE.
- `rom_addr` out ROM_AW: registered address to `rom16`.
- `rom_data` in 8: `rom16` dout; valid one cycle after `rom_addr` is sampled.

## Operation
- Registers:
  - `addr[15:0]`
  - `buf[7:0]`: prefetch buffer.
  - `phase`: address-byte toggle.
  - `state` ∈ {IDLE, ACK, FETCH, LOAD}.
- Requests are accepted only in IDLE. A `req` in any other state is ignored, with no state change.
- Address write (`mode`=1, `we`=1):
  - `addr` ← {addr[7:0], din}; `phase` toggles.
  - If `phase` was 0: go to ACK.
  - If `phase` was 1: go to FETCH (prefetch).
- Address read (`mode`=1, `we`=0):
  - `dout` ← addr[15:8] if `phase`=0, else addr[7:0].
  - `phase` toggles; go to ACK. No ROM access.
- Data read (`mode`=0, `we`=0): `dout` ← `buf`; `phase` ← 0; go to FETCH.
- Data write (`mode`=0, `we`=1): `din` discarded; `phase` ← 0; go to FETCH. The ROM is not written.
- State transitions:
  - FETCH: `rom_addr` holds addr[ROM_AW-1:0], loaded on entry; → LOAD.
  - LOAD: `buf` ← `rom_data`; addr[ROM_AW-1:0] ← addr[ROM_AW-1:0]+1 modulo 2^ROM_AW; addr[15:ROM_AW] unchanged; → IDLE.
  - ACK: → IDLE.
- `ack` = 1 exactly in ACK and LOAD.
- Reset, asynchronous and at any point including mid-prefetch:
  - `addr`, `buf`, `dout`, `rom_addr`, `phase` = 0.
  - `state` = IDLE; `ack` = `busy` = 0.
  - An aborted prefetch leaves `buf` = 0 and is not resumed.

## Timing
- `req` in cycle T.
- Address read and first address write: `ack` in T+1; `busy` in T+1; IDLE in T+2.
- Second address write, data read and data write:
  - `rom_addr` valid in T+1 (FETCH).
  - `rom_data` valid in T+2 (LOAD); `ack` in T+2.
  - `buf` and `addr` updated at the end of T+2; next `req` is legal in T+3.
- Data read: `dout` shows the pre-fetch `buf` from T+1. `dout` is never overwritten by the prefetch.
- Back-to-back reads return consecutive ROM bytes. Throughput is one access per 3 cycles.

## Structure
- Shared package `grom_pkg`:
  - state encoding constants;
  - `MODE_DATA`/`MODE_ADDR` constants.
- Single flat module with no sub-modules. `rom16` is instantiated by the parent, with `rom16.DEPTH` = `ROM_AW`.

## Test plan
- Reset with outputs forced busy mid-FETCH → all outputs 0 and `state` IDLE in the same cycle. After release, `busy`=0.
- ROM[0x123]=0xAA, ROM[0x124]=0x55. Address writes 0x61 then 0x23:
  - `rom_addr`=0x123 in FETCH.
  - Data read → `dout`=0xAA. Second data read → `dout`=0x55.
  - Address reads → 0x61, then 0x26.
- Address writes 0x7F, 0xFF → `rom_addr`=0x1FFF. Address reads → 0x60, 0x00 (wrap within 8K; upper bits kept).
- Address write 0x12, then a data read (`phase` cleared), then address writes 0x40, 0x10:
  - `addr` = 0x4010 before increment.
  - Prefetch `rom_addr`=0x010.
  - Address reads → 0x40, 0x11.
- Data write 0x99 at addr 0x6000 → `ack` at T+2; address reads → 0x60, 0x01; ROM contents unchanged.
- `req` asserted during FETCH and LOAD → ignored; exactly one `ack`; `addr` advances by one only.
